// File: rtl/segmentos_7_seq.sv
`default_nettype none
// ============================================================================
// Module      : segmentos_7_seq
// Description : Sequential binary-to-BCD converter (double dabble, one step
//               per clock) driving DIGITS seven-segment displays, with
//               optional leading-zero blanking and overflow dash display.
// Revision    : 1.0  initial release
// ============================================================================
module segmentos_7_seq #(
    parameter int WIDTH      = 8,
    parameter int DIGITS     = 3,
    parameter int BLANK_LZ   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      input_signal,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);

    // Number of decimal digits needed to hold 2^w-1 (w <= 20 fits in 7).
    function automatic int f_dec_digits(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (v > 0) begin
                n = n + 1;
                v = v / 10;
            end
        end
        if (n < 1) begin
            n = 1;
        end
        return n;
    endfunction

    // Active-high segment pattern for one decimal digit, bit0=a .. bit6=g.
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Accumulator keeps every digit the input can produce so overflow is
    // detectable and no bit is shifted out during the conversion.
    localparam int c_ND_RAW = f_dec_digits(WIDTH);
    localparam int c_ND     = (c_ND_RAW > DIGITS) ? c_ND_RAW : DIGITS;
    localparam int c_AW     = 4 * c_ND;
    localparam int c_CW     = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam logic [6:0]      c_INV      = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0]      c_DASH     = 7'h40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [WIDTH-1:0]        r_sh;
    logic [c_AW-1:0]         r_acc;
    logic [c_CW-1:0]         r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_ovf;
    logic [4*DIGITS-1:0]     r_bcd;
    logic [7*DIGITS-1:0]     r_hex;

    logic [c_AW-1:0]         w_acc_adj;
    logic [c_AW+WIDTH-1:0]   w_shifted;
    logic                    w_ovf;
    logic                    w_seen;
    logic [6:0]              w_code;
    logic [7*DIGITS-1:0]     w_hex;

    // State register; reset always wins, discarding any partial conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: WIDTH conversion cycles, then a single DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_CONV;
            ST_CONV: if (r_cnt == c_CNT_LAST) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
    always_comb begin
        w_acc_adj = r_acc;
        for (int k = 0; k < c_ND; k++) begin
            if (r_acc[4*k +: 4] >= 4'd5) begin
                w_acc_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
            end
        end
        w_shifted = {w_acc_adj, r_sh} << 1;
    end

    // Overflow: any accumulator digit beyond the displayed ones is nonzero.
    always_comb begin
        w_ovf = 1'b0;
        for (int k = DIGITS; k < c_ND; k++) begin
            if (r_acc[4*k +: 4] != 4'd0) begin
                w_ovf = 1'b1;
            end
        end
    end

    // Segment encoding, scanning from the top digit to find leading zeros.
    always_comb begin
        w_hex  = '0;
        w_seen = 1'b0;
        w_code = 7'h00;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_seen = w_seen | (r_acc[4*k +: 4] != 4'd0);
            if (w_ovf) begin
                w_code = c_DASH;
            end else if (w_seen || (k == 0) || (BLANK_LZ == 0)) begin
                w_code = f_seg(r_acc[4*k +: 4]);
            end else begin
                w_code = 7'h00;
            end
            w_hex[7*k +: 7] = w_code ^ c_INV;
        end
    end

    // Datapath and registered outputs, sequenced by the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_bcd  <= '0;
            r_hex  <= {DIGITS{c_INV}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sh   <= input_signal;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                ST_CONV: begin
                    r_acc <= w_shifted[c_AW+WIDTH-1:WIDTH];
                    r_sh  <= w_shifted[WIDTH-1:0];
                    r_cnt <= r_cnt + c_CW'(1);
                end
                ST_DONE: begin
                    r_bcd  <= r_acc[4*DIGITS-1:0];
                    r_hex  <= w_hex;
                    r_ovf  <= w_ovf;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign bcd  = r_bcd;
    assign hex  = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_segmentos_7_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_segmentos_7_seq
// Description : Self-checking bench for segmentos_7_seq. Four instances with
//               different parameter sets are compared every cycle against a
//               decimal-arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_segmentos_7_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st8;
    logic        st12;
    logic [7:0]  in8;
    logic [11:0] in12;
    logic        chk_en;

    int total = 0;
    int bad   = 0;

    // Instance parameters: u0 defaults, u1 W12/D4/no-blank/active-high,
    // u2 W12/D3, u3 W8/D2. u0,u3 share the 8-bit stimulus; u1,u2 the 12-bit.
    localparam int P_W   [4] = '{8, 12, 12, 8};
    localparam int P_D   [4] = '{3, 4, 3, 2};
    localparam int P_BLZ [4] = '{1, 0, 1, 1};
    localparam int P_AL  [4] = '{1, 0, 1, 1};
    localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic        busy2, done2, ovf2, busy3, done3, ovf3;
    logic [11:0] bcd0;
    logic [20:0] hex0;
    logic [15:0] bcd1;
    logic [27:0] hex1;
    logic [11:0] bcd2;
    logic [20:0] hex2;
    logic [7:0]  bcd3;
    logic [13:0] hex3;

    segmentos_7_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1), .ACTIVE_LOW(1)) u0 (
        .clk(clk), .rst(rst), .start(st8), .input_signal(in8),
        .busy(busy0), .done(done0), .ovf(ovf0), .bcd(bcd0), .hex(hex0));
    segmentos_7_seq #(.WIDTH(12), .DIGITS(4), .BLANK_LZ(0), .ACTIVE_LOW(0)) u1 (
        .clk(clk), .rst(rst), .start(st12), .input_signal(in12),
        .busy(busy1), .done(done1), .ovf(ovf1), .bcd(bcd1), .hex(hex1));
    segmentos_7_seq #(.WIDTH(12), .DIGITS(3), .BLANK_LZ(1), .ACTIVE_LOW(1)) u2 (
        .clk(clk), .rst(rst), .start(st12), .input_signal(in12),
        .busy(busy2), .done(done2), .ovf(ovf2), .bcd(bcd2), .hex(hex2));
    segmentos_7_seq #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(1), .ACTIVE_LOW(1)) u3 (
        .clk(clk), .rst(rst), .start(st8), .input_signal(in8),
        .busy(busy3), .done(done3), .ovf(ovf3), .bcd(bcd3), .hex(hex3));

    logic        a_busy [4];
    logic        a_done [4];
    logic        a_ovf  [4];
    logic [23:0] a_bcd  [4];
    logic [41:0] a_hex  [4];

    assign a_busy[0] = busy0;  assign a_done[0] = done0;  assign a_ovf[0] = ovf0;
    assign a_busy[1] = busy1;  assign a_done[1] = done1;  assign a_ovf[1] = ovf1;
    assign a_busy[2] = busy2;  assign a_done[2] = done2;  assign a_ovf[2] = ovf2;
    assign a_busy[3] = busy3;  assign a_done[3] = done3;  assign a_ovf[3] = ovf3;
    assign a_bcd[0] = 24'(bcd0);  assign a_hex[0] = 42'(hex0);
    assign a_bcd[1] = 24'(bcd1);  assign a_hex[1] = 42'(hex1);
    assign a_bcd[2] = 24'(bcd2);  assign a_hex[2] = 42'(hex2);
    assign a_bcd[3] = 24'(bcd3);  assign a_hex[3] = 42'(hex3);

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic int pow10(input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] pol(input int i, input logic [6:0] c);
        return (P_AL[i] != 0) ? ~c : c;
    endfunction

    function automatic logic [23:0] f_bcd(input int i, input int v);
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < P_D[i]; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [41:0] f_hex(input int i, input int v);
        logic [41:0] r;
        logic [6:0]  c;
        logic        ov;
        r  = '0;
        ov = (v >= pow10(P_D[i]));
        for (int k = 0; k < P_D[i]; k++) begin
            if (ov)
                c = 7'h40;
            else if (k == 0 || P_BLZ[i] == 0 || v >= pow10(k))
                c = SEG[(v / pow10(k)) % 10];
            else
                c = 7'h00;
            r[7*k +: 7] = pol(i, c);
        end
        return r;
    endfunction

    function automatic logic [41:0] f_blank(input int i);
        logic [41:0] r;
        r = '0;
        for (int k = 0; k < P_D[i]; k++) r[7*k +: 7] = pol(i, 7'h00);
        return r;
    endfunction

    int          m_cnt  [4];
    int          m_val  [4];
    logic        m_busy [4];
    logic        m_done [4];
    logic        m_ovf  [4];
    logic [23:0] m_bcd  [4];
    logic [41:0] m_hex  [4];
    int          mdl_s;
    int          mdl_v;

    // Model: a request is accepted when idle, result appears WIDTH+1 edges later.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            mdl_s = (i == 0 || i == 3) ? int'(st8) : int'(st12);
            mdl_v = (i == 0 || i == 3) ? int'(in8) : int'(in12);
            if (rst) begin
                m_cnt[i]  = 0;
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_ovf[i]  = 1'b0;
                m_bcd[i]  = '0;
                m_hex[i]  = f_blank(i);
            end else begin
                m_done[i] = 1'b0;
                if (m_cnt[i] == 0) begin
                    if (mdl_s != 0) begin
                        m_val[i]  = mdl_v;
                        m_cnt[i]  = P_W[i] + 1;
                        m_busy[i] = 1'b1;
                    end
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_ovf[i]  = (m_val[i] >= pow10(P_D[i]));
                        m_bcd[i]  = f_bcd(i, m_val[i]);
                        m_hex[i]  = f_hex(i, m_val[i]);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                chk("busy", i, 64'(a_busy[i]), 64'(m_busy[i]));
                chk("done", i, 64'(a_done[i]), 64'(m_done[i]));
                chk("ovf",  i, 64'(a_ovf[i]),  64'(m_ovf[i]));
                chk("bcd",  i, 64'(a_bcd[i]),  64'(m_bcd[i]));
                chk("hex",  i, 64'(a_hex[i]),  64'(m_hex[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic go8(input logic [7:0] v, output int lat);
        @(negedge clk);
        in8 = v;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        lat = 0;
        while (!a_done[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic go12(input logic [11:0] v, output int lat);
        @(negedge clk);
        in12 = v;
        st12 = 1'b1;
        @(negedge clk);
        st12 = 1'b0;
        lat = 0;
        while (!a_done[1] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int npulse;

    initial begin
        rst = 1'b1; st8 = 1'b0; st12 = 1'b0; in8 = '0; in12 = '0; chk_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state pinned by literals.
        chk("rst_hex_al", 0, 64'(a_hex[0]), 64'h1FFFFF);
        chk("rst_hex_ah", 1, 64'(a_hex[1]), 64'h0);
        chk("rst_bcd",    0, 64'(a_bcd[0]), 64'h0);
        chk("rst_busy",   0, 64'(a_busy[0]), 64'h0);

        // 255 on defaults: latency 9, digits 2,5,5.
        go8(8'd255, lat);
        chk("lat255", 0, 64'(lat), 64'd9);
        chk("bcd255", 0, 64'(a_bcd[0]), 64'h255);
        chk("hex255", 0, 64'(a_hex[0]), 64'({~7'h5B, ~7'h6D, ~7'h6D}));
        chk("ovf255", 0, 64'(a_ovf[0]), 64'h0);

        // 7: leading zeros blanked.
        go8(8'd7, lat);
        chk("bcd7",  0, 64'(a_bcd[0]), 64'h007);
        chk("hex7",  0, 64'(a_hex[0]), 64'({7'h7F, 7'h7F, ~7'h07}));

        // 100: overflow on two digits, plain on three.
        go8(8'd100, lat);
        chk("ovf100_d2", 3, 64'(a_ovf[3]), 64'h1);
        chk("bcd100_d2", 3, 64'(a_bcd[3]), 64'h00);
        chk("hex100_d2", 3, 64'(a_hex[3]), 64'({~7'h40, ~7'h40}));
        chk("hex100_d3", 0, 64'(a_hex[0]), 64'({~7'h06, ~7'h3F, ~7'h3F}));

        // 7 without blanking, active-high.
        go12(12'd7, lat);
        chk("lat12",  1, 64'(lat), 64'd13);
        chk("bcd7_w", 1, 64'(a_bcd[1]), 64'h0007);
        chk("hex7_w", 1, 64'(a_hex[1]), 64'({7'h3F, 7'h3F, 7'h3F, 7'h07}));

        // 1000 on three digits: dashes.
        go12(12'd1000, lat);
        chk("ovf1000", 2, 64'(a_ovf[2]), 64'h1);
        chk("hex1000", 2, 64'(a_hex[2]), 64'({~7'h40, ~7'h40, ~7'h40}));

        // Random single conversions.
        for (int n = 0; n < 30; n++) begin
            go8(8'($urandom), lat);
            chk("lat_rand", 0, 64'(lat), 64'd9);
        end

        // start held high, input changing every cycle.
        npulse = 0;
        @(negedge clk);
        st8 = 1'b1;
        for (int n = 0; n < 60; n++) begin
            in8 = 8'($urandom);
            @(negedge clk);
            if (a_done[0]) npulse++;
        end
        st8 = 1'b0;
        chk("b2b_pulses", 0, 64'(npulse), 64'd6);
        repeat (3) @(negedge clk);

        // Reset in the middle of a conversion.
        go8(8'd255, lat);
        @(negedge clk);
        in8 = 8'd42;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        st8 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        st8 = 1'b0;
        chk("mid_rst_busy", 0, 64'(a_busy[0]), 64'h0);
        chk("mid_rst_done", 0, 64'(a_done[0]), 64'h0);
        chk("mid_rst_bcd",  0, 64'(a_bcd[0]), 64'h0);
        chk("mid_rst_hex",  0, 64'(a_hex[0]), 64'h1FFFFF);
        npulse = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (a_done[0]) npulse++;
        end
        chk("mid_rst_nodone", 0, 64'(npulse), 64'd0);
        go8(8'd42, lat);
        chk("lat42", 0, 64'(lat), 64'd9);
        chk("bcd42", 0, 64'(a_bcd[0]), 64'h042);
        chk("hex42", 0, 64'(a_hex[0]), 64'({7'h7F, ~7'h66, ~7'h5B}));

        // Full 12-bit sweep on four and three digits.
        for (int v = 0; v < 4096; v++) begin
            go12(12'(v), lat);
            chk("lat_sweep", 1, 64'(lat), 64'd13);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
